// File: rtl/output_hash_gen_pkg.sv
// Shared definitions for the output write-channel hash generator:
// register offsets, CTRL bit positions, FSM state type and default seed.
package output_hash_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Register word index, i.e. address bits [4:2]
  localparam logic [2:0] REG_CTRL        = 3'd0;
  localparam logic [2:0] REG_STATUS      = 3'd1;
  localparam logic [2:0] REG_HASH        = 3'd2;
  localparam logic [2:0] REG_BEAT_CNT    = 3'd3;
  localparam logic [2:0] REG_BURST_CNT   = 3'd4;
  localparam logic [2:0] REG_OUTSTANDING = 3'd5;

  localparam int CTRL_CLEAR_BIT = 0;
  localparam int CTRL_ARM_BIT   = 1;
  localparam int CTRL_SEAL_BIT  = 2;

  localparam logic [31:0] DEFAULT_HASH_SEED = 32'h811C9DC5;
  localparam logic [1:0]  BRESP_OKAY        = 2'b00;

endpackage

// File: rtl/output_hash_gen_hash_fold_lane.sv
// Byte-masked XOR fold of a wide AXI data beat down to 32 bits, plus the
// rotate-left-by-one-then-xor hash step. Shared with the read-side checker.
module hash_fold_lane
  import output_hash_gen_pkg::*;
#(
  parameter int AXI_WIDTH = 128
) (
  input  logic [AXI_WIDTH-1:0]   wdata_i,
  input  logic [AXI_WIDTH/8-1:0] wstrb_i,
  input  logic [31:0]            hash_i,
  output logic [31:0]            fold_o,
  output logic [31:0]            hash_next_o
);

  localparam int LANES = AXI_WIDTH / 32;

  always_comb begin
    fold_o = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[4*l+b]) begin
          fold_o[8*b +: 8] = fold_o[8*b +: 8] ^ wdata_i[32*l + 8*b +: 8];
        end
      end
    end
  end

  assign hash_next_o = {hash_i[30:0], hash_i[31]} ^ fold_o;

endmodule

// File: rtl/output_hash_gen.sv
// Passive snooper on the accelerator's AXI4 output write channel: folds accepted
// W beats into a 32-bit signature, tracks outstanding bursts, exposes registers.
module output_hash_gen
  import output_hash_gen_pkg::*;
#(
  parameter int          AXI_WIDTH       = 128,
  parameter int          AXI_STRB_WIDTH  = AXI_WIDTH / 8,
  parameter int          AXIL_WIDTH      = 32,
  parameter int          AXIL_ADDR_WIDTH = 40,
  parameter int          STRB_WIDTH      = 4,
  parameter int          OUTST_WIDTH     = 8,
  parameter logic [31:0] HASH_SEED       = DEFAULT_HASH_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       awvalid_i,
  input  logic                       awready_i,
  input  logic [AXI_WIDTH-1:0]       wdata_i,
  input  logic [AXI_STRB_WIDTH-1:0]  wstrb_i,
  input  logic                       wlast_i,
  input  logic                       wvalid_i,
  input  logic                       wready_i,
  input  logic                       bvalid_i,
  input  logic                       bready_i,
  input  logic [1:0]                 bresp_i,
  input  logic [AXIL_ADDR_WIDTH-1:0] reg_wr_addr_i,
  input  logic [AXIL_WIDTH-1:0]      reg_wr_data_i,
  input  logic [STRB_WIDTH-1:0]      reg_wr_strb_i,
  input  logic                       reg_wr_en_i,
  output logic                       reg_wr_ack_o,
  input  logic [AXIL_ADDR_WIDTH-1:0] reg_rd_addr_i,
  input  logic                       reg_rd_en_i,
  output logic [AXIL_WIDTH-1:0]      reg_rd_data_o,
  output logic                       reg_rd_ack_o,
  output logic                       hash_done_o
);

  localparam logic [OUTST_WIDTH-1:0] OUTST_ONE = OUTST_WIDTH'(1);
  localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = '1;
  localparam logic [AXIL_WIDTH-1:0]  CNT_ONE   = AXIL_WIDTH'(1);

  state_e                  state_q;
  logic                    hash_done_q;
  logic [31:0]             hash_q, hash_d;
  logic [AXIL_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [AXIL_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;
  logic [OUTST_WIDTH-1:0]  outst_q, outst_d;
  logic                    err_uf_q, err_uf_d;
  logic                    err_bresp_q, err_bresp_d;
  logic                    wr_ack_q, rd_ack_q;
  logic [AXIL_WIDTH-1:0]   rd_data_q, rd_mux;

  logic        aw_hs, w_hs, b_hs, absorb, busy, done;
  logic        ctrl_wr, ctrl_clear, ctrl_arm, ctrl_seal;
  logic [31:0] beat_fold, hash_next;
  logic        unused_bits;

  assign aw_hs  = awvalid_i & awready_i;
  assign w_hs   = wvalid_i & wready_i;
  assign b_hs   = bvalid_i & bready_i;
  assign busy   = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign done   = (state_q == ST_DONE);
  assign absorb = w_hs & busy;

  assign ctrl_wr    = reg_wr_en_i & reg_wr_strb_i[0] & (reg_wr_addr_i[4:2] == REG_CTRL);
  assign ctrl_clear = ctrl_wr & reg_wr_data_i[CTRL_CLEAR_BIT];
  assign ctrl_arm   = ctrl_wr & reg_wr_data_i[CTRL_ARM_BIT];
  assign ctrl_seal  = ctrl_wr & reg_wr_data_i[CTRL_SEAL_BIT];

  hash_fold_lane #(.AXI_WIDTH(AXI_WIDTH)) u_fold (
    .wdata_i     (wdata_i),
    .wstrb_i     (wstrb_i),
    .hash_i      (hash_q),
    .fold_o      (beat_fold),
    .hash_next_o (hash_next)
  );

  // Simultaneous AW and B cancel; saturation at either end flags the shared error bit.
  always_comb begin
    hash_d      = hash_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    outst_d     = outst_q;
    err_uf_d    = err_uf_q;
    err_bresp_d = err_bresp_q;
    if (absorb) begin
      hash_d      = hash_next;
      beat_cnt_d  = beat_cnt_q + CNT_ONE;
      burst_cnt_d = burst_cnt_q + {{(AXIL_WIDTH-1){1'b0}}, wlast_i};
    end
    if (aw_hs && !b_hs) begin
      if (outst_q == OUTST_MAX) err_uf_d = 1'b1;
      else                      outst_d  = outst_q + OUTST_ONE;
    end else if (b_hs && !aw_hs) begin
      if (outst_q == '0) err_uf_d = 1'b1;
      else               outst_d  = outst_q - OUTST_ONE;
    end
    if (b_hs && (bresp_i != BRESP_OKAY)) err_bresp_d = 1'b1;
    if (ctrl_clear) begin
      hash_d      = HASH_SEED;
      beat_cnt_d  = '0;
      burst_cnt_d = '0;
      outst_d     = '0;
      err_uf_d    = 1'b0;
      err_bresp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_q      <= HASH_SEED;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      outst_q     <= '0;
      err_uf_q    <= 1'b0;
      err_bresp_q <= 1'b0;
    end else begin
      hash_q      <= hash_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      outst_q     <= outst_d;
      err_uf_q    <= err_uf_d;
      err_bresp_q <= err_bresp_d;
    end
  end

  // CLEAR wins over ARM/SEAL in the same CTRL word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hash_done_q <= 1'b0;
    end else if (ctrl_clear) begin
      state_q     <= ST_IDLE;
      hash_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:   if (ctrl_arm) state_q <= ST_ACTIVE;
        ST_ACTIVE: if (ctrl_seal) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if ((outst_q == '0) && !w_hs) begin
            state_q     <= ST_DONE;
            hash_done_q <= 1'b1;
          end
        end
        ST_DONE:   state_q <= ST_DONE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_rd_addr_i[4:2])
      REG_STATUS:      rd_mux = {{(AXIL_WIDTH-4){1'b0}}, err_uf_q, err_bresp_q, busy, done};
      REG_HASH:        rd_mux = hash_q;
      REG_BEAT_CNT:    rd_mux = beat_cnt_q;
      REG_BURST_CNT:   rd_mux = burst_cnt_q;
      REG_OUTSTANDING: rd_mux = {{(AXIL_WIDTH-OUTST_WIDTH){1'b0}}, outst_q};
      default:         rd_mux = '0;
    endcase
  end

  // Read data samples pre-update state, so a same-cycle beat is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ack_q  <= reg_wr_en_i;
      rd_ack_q  <= reg_rd_en_i;
      rd_data_q <= reg_rd_en_i ? rd_mux : '0;
    end
  end

  assign reg_wr_ack_o  = wr_ack_q;
  assign reg_rd_ack_o  = rd_ack_q;
  assign reg_rd_data_o = rd_data_q;
  assign hash_done_o   = hash_done_q;

  assign unused_bits = ^{reg_wr_addr_i[AXIL_ADDR_WIDTH-1:5], reg_wr_addr_i[1:0],
                         reg_rd_addr_i[AXIL_ADDR_WIDTH-1:5], reg_rd_addr_i[1:0],
                         reg_wr_strb_i[STRB_WIDTH-1:1], reg_wr_data_i[AXIL_WIDTH-1:3],
                         beat_fold};

endmodule
